// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Opcodes, reply words and FSM encoding for spi_cmd_engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    localparam logic [7:0] OP_PING  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_COUNT = 8'h04;

    localparam logic [31:0] RSP_PONG         = 32'h504F_4E47;
    localparam logic [31:0] RSP_OK           = 32'h0000_0001;
    localparam logic [31:0] RSP_BADOP_BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] RSP_TIMEOUT_BASE = 32'hDEAD_0000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH_CMD = 4'd1,
        ST_WAIT_CMD  = 4'd2,
        ST_DECODE    = 4'd3,
        ST_FETCH_ARG = 4'd4,
        ST_WAIT_ARG  = 4'd5,
        ST_MEM       = 4'd6,
        ST_SEND      = 4'd7,
        ST_WAIT_SEND = 4'd8
    } state_t;

    // Reply for every opcode that completes without touching memory.
    function automatic logic [31:0] direct_reply(input logic [7:0] op, input logic [15:0] cnt);
        logic [31:0] r;
        case (op)
            OP_PING:  r = RSP_PONG;
            OP_COUNT: r = {16'h0000, cnt};
            default:  r = RSP_BADOP_BASE | {24'h00_0000, op};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_engine
// Description : Decodes host command words from the SPI bridge RX FIFO, runs
//               memory accesses and returns one reply word per command.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_engine
    import spi_cmd_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_fifo_empty,
    input  logic        tx_fifo_full,
    output logic        bus_read,
    input  logic        bus_read_response,
    input  logic [31:0] bus_read_data,
    output logic        bus_write,
    output logic [31:0] bus_write_data,
    input  logic        bus_write_response,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] cmd_count
);

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t        r_state;
    logic [31:0]   r_cmd;
    logic [31:0]   r_wdata;
    logic [31:0]   r_reply;
    logic [TW-1:0] r_tmo_cnt;
    logic [15:0]   r_cmd_count;

    logic [7:0]    w_opcode;
    logic          w_fetching;

    assign w_opcode   = r_cmd[31:24];
    assign w_fetching = (r_state == ST_FETCH_CMD) || (r_state == ST_FETCH_ARG);

    // Handshake requests are gated by the live FIFO flags so a flag change in
    // the request cycle itself can never produce an illegal pulse.
    assign bus_read       = w_fetching && !rx_fifo_empty;
    assign bus_write      = (r_state == ST_SEND) && !tx_fifo_full;
    assign bus_write_data = r_reply;
    assign mem_req        = (r_state == ST_MEM);
    assign mem_we         = mem_req && (w_opcode == OP_WRITE);
    assign mem_addr       = {6'b00_0000, r_cmd[23:0], 2'b00};
    assign mem_wdata      = r_wdata;
    assign cmd_count      = r_cmd_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_wdata     <= '0;
            r_reply     <= '0;
            r_tmo_cnt   <= '0;
            r_cmd_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH_CMD;
                ST_FETCH_CMD: begin
                    if (!rx_fifo_empty) r_state <= ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    if (bus_read_response) begin
                        r_cmd   <= bus_read_data;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_tmo_cnt <= '0;
                    if (w_opcode == OP_WRITE) begin
                        r_state <= ST_FETCH_ARG;
                    end else if (w_opcode == OP_READ) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_reply <= direct_reply(w_opcode, r_cmd_count);
                        r_state <= ST_SEND;
                    end
                end
                ST_FETCH_ARG: begin
                    if (!rx_fifo_empty) r_state <= ST_WAIT_ARG;
                end
                ST_WAIT_ARG: begin
                    if (bus_read_response) begin
                        r_wdata <= bus_read_data;
                        r_state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    // An ack in the final counted cycle still beats the timeout.
                    if (mem_ack) begin
                        r_reply <= (w_opcode == OP_WRITE) ? RSP_OK : mem_rdata;
                        r_state <= ST_SEND;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_reply <= RSP_TIMEOUT_BASE | {24'h00_0000, w_opcode};
                        r_state <= ST_SEND;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                ST_SEND: begin
                    if (!tx_fifo_full) r_state <= ST_WAIT_SEND;
                end
                ST_WAIT_SEND: begin
                    if (bus_write_response) begin
                        r_cmd_count <= r_cmd_count + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_engine.md
# spi_cmd_engine

Command engine sitting directly upstream of the SPI bridge's bus port. It consumes 32-bit words the host shifts in over SPI, drawing them from the bridge's RX FIFO via the read/read_response handshake. It decodes each word as a command, performs the requested memory access on a simple request/ack memory port, and returns one 32-bit reply per command into the bridge's TX FIFO via the write/write_response handshake.

## Interface
- MEM_TIMEOUT, 1024: cycles to wait for mem_ack before abandoning an access; must be ≥ 2.
- clk  in  1  single clock, shared with the bridge.
- reset  in  1  asynchronous, active-high reset.
- rx_fifo_empty  in  1  bridge RX FIFO empty.
- tx_fifo_full  in  1  bridge TX FIFO full.
- bus_read  out  1  one-cycle read request to the bridge.
- bus_read_response  in  1  one-cycle pulse; bus_read_data valid this cycle.
- bus_read_data  in  32  word received from host.
- bus_write  out  1  one-cycle write request to the bridge.
- bus_write_data  out  32  reply word; held stable from the bus_write cycle until bus_write_response.
- bus_write_response  in  1  one-cycle write completion pulse.
- mem_req  out  1  memory request; level, held until mem_ack or timeout.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  byte address, {6'b0, imm[23:0], 2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- cmd_count  out  16  completed commands; wraps 0xFFFF→0x0000.

## Operation
- Command word: opcode = bits[31:24], imm = bits[23:0].
- Opcodes:
  - 0x01 PING: reply 0x504F4E47.
  - 0x02 WRITE: fetch one argument word, write it to imm, reply 0x00000001.
  - 0x03 READ: read from imm, reply with mem_rdata.
  - 0x04 COUNT: reply {16'h0, cmd_count}.
  - Any other opcode: reply 0xFFFFFF00 | opcode.
- Timeout: mem_ack absent for MEM_TIMEOUT cycles after mem_req rises → drop mem_req, reply 0xDEAD0000 | opcode.
- FSM states:
  - IDLE: go to FETCH_CMD.
  - FETCH_CMD: if !rx_fifo_empty, pulse bus_read and go to WAIT_CMD.
  - WAIT_CMD: on bus_read_response, latch the word and go to DECODE.
  - DECODE: WRITE → FETCH_ARG; READ → MEM; otherwise load the reply and go to SEND.
  - FETCH_ARG / WAIT_ARG: same handshake as FETCH_CMD / WAIT_CMD; latch mem_wdata, then go to MEM.
  - MEM: mem_req=1; on mem_ack or timeout, load the reply and go to SEND.
  - SEND: if !tx_fifo_full, pulse bus_write and go to WAIT_SEND.
  - WAIT_SEND: on bus_write_response, cmd_count += 1 and go to IDLE.
- Exactly one reply per command, including errors and timeouts.
- Commands are processed strictly in order; no pipelining.

## Timing
- Reset values: all outputs 0, cmd_count = 0, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-operation abandons any in-flight bus or memory transaction immediately. A mem_ack or bridge response arriving after reset is ignored.
- bus_read is never asserted while rx_fifo_empty = 1.
- bus_write is never asserted while tx_fifo_full = 1.
- Request pulses are exactly 1 cycle. No new request is issued until the previous one's response has arrived.
- PING latency: bus_read_response seen in cycle N → bus_write in N+2 when the TX FIFO is not full. Each cycle tx_fifo_full = 1 in SEND adds one cycle.
- READ latency: mem_req rises in N+2. mem_ack in cycle M → bus_write in M+1, carrying the mem_rdata captured in cycle M.
- Timeout counter: starts at 0 on entry to MEM and increments each cycle mem_ack = 0. When it reaches MEM_TIMEOUT−1, mem_req drops the next cycle.
- mem_ack in the same cycle the counter reaches its limit: the ack wins and the reply is the normal one.
- mem_ack outside MEM: ignored.
- Unexpected bus_read_response or bus_write_response outside the WAIT_* states: ignored.

## Structure
- Shared package spi_cmd_pkg holds:
  - opcode constants OP_PING, OP_WRITE, OP_READ, OP_COUNT;
  - reply constants RSP_PONG, RSP_OK, RSP_BADOP_BASE, RSP_TIMEOUT_BASE;
  - the FSM state encoding.
- Single module; no sub-module. The timeout counter is inline, $clog2(MEM_TIMEOUT) bits wide.

## Test plan
- PING: RX delivers 0x01000000 → one bus_write of 0x504F4E47, issued 2 cycles after bus_read_response; cmd_count = 1.
- WRITE then READ: RX delivers 0x02000010, 0xCAFEBABE → mem write at addr 0x40 with wdata 0xCAFEBABE, reply 0x00000001. RX then delivers 0x03000010 with memory returning 0xCAFEBABE → reply 0xCAFEBABE.
- Bad opcode: RX delivers 0x7F000000 → reply 0xFFFFFF7F; no mem_req.
- Timeout (MEM_TIMEOUT=8): READ with mem_ack never asserted → mem_req high for exactly 8 cycles, reply 0xDEAD0003. A late mem_ack is ignored.
- Backpressure: hold tx_fifo_full=1 for 20 cycles during PING → no bus_write until it is released, then exactly one. Likewise rx_fifo_empty=1 → no bus_read.
- Async reset asserted mid-MEM → outputs 0 without waiting for clk; after release, a PING completes normally with cmd_count = 1.
